// File: rtl/ftdi_pkg.sv
// Shared FTDI TX framing definitions: FSM state encoding and tag byte format.
// No logic of its own; imported by the arbiter and the bus interface users.
// The tag byte is {TAG_PREFIX, TAG_PAD, source id}.
package ftdi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_TAG     = 3'd1,
    ST_LEN_H   = 3'd2,
    ST_LEN_L   = 3'd3,
    ST_PAYLOAD = 3'd4
  } state_e;

  localparam logic [3:0] TAG_PREFIX = 4'hA;
  localparam logic [1:0] TAG_PAD    = 2'b00;

  // Builds the frame tag byte for a source index.
  function automatic logic [7:0] make_tag(input logic [1:0] id);
    return {TAG_PREFIX, TAG_PAD, id};
  endfunction

endpackage

// File: rtl/tx_frame_arbiter_if.sv
// Bundle of request-side and FTDI-TX-FIFO-side signals of the frame arbiter.
// Pure wiring, no latency.
// master = arbiter (drives acks and FIFO writes), slave = sources + FIFO.
interface tx_frame_arbiter_if #(
  parameter int NREQ = 2,
  parameter int LENW = 16
) ();

  logic [NREQ-1:0]      req_valid;
  logic [NREQ*LENW-1:0] req_len;
  logic [NREQ*8-1:0]    req_data;
  logic [NREQ-1:0]      req_ack;
  logic [7:0]           wi_data;
  logic                 wi_write;
  logic                 wi_full;
  logic [NREQ-1:0]      grant;
  logic [2:0]           state;

  modport master (
    input  req_valid, req_len, req_data, wi_full,
    output req_ack, wi_data, wi_write, grant, state
  );

  modport slave (
    output req_valid, req_len, req_data, wi_full,
    input  req_ack, wi_data, wi_write, grant, state
  );

endinterface

// File: rtl/rr_pick.sv
// Round-robin winner select: one-hot grant of the first request at or after ptr.
// Purely combinational, zero latency.
// No backpressure; output is all zero when no request is set.
module rr_pick #(
  parameter int NREQ = 2,
  parameter int PW   = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] win
);

  logic found;

  // Scan ptr..NREQ-1 first, then wrap to 0..ptr-1; first hit wins.
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && (i >= int'(ptr)) && req[i]) begin
        win[i] = 1'b1;
        found  = 1'b1;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!found && (i < int'(ptr)) && req[i]) begin
        win[i] = 1'b1;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tx_frame_arbiter.sv
// Arbitrates NREQ frame sources onto the FTDI TX FIFO: tag, len MSB, len LSB, payload.
// Tag appears one cycle after a request is seen in IDLE; one IDLE cycle between frames.
// wi_full stalls every byte in place; nothing is written or acked while it is high.
module tx_frame_arbiter
  import ftdi_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int LENW = 16
) (
  input logic                clk,
  input logic                res,
  tx_frame_arbiter_if.master bus
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_e          state_q, state_d;
  logic [NREQ-1:0] grant_q;
  logic [NREQ-1:0] win;
  logic [1:0]      gid_q;
  logic [1:0]      win_id;
  logic [PW-1:0]   ptr_q;
  logic [PW-1:0]   ptr_nxt;
  logic [LENW-1:0] len_reg;
  logic [LENW-1:0] cnt;
  logic [LENW-1:0] win_len;
  logic [15:0]     len16;
  logic [7:0]      pay_byte;
  logic [7:0]      out_byte;
  logic            start;
  logic            wr;
  logic            pay_wr;

  rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_rr_pick (
    .req (bus.req_valid),
    .ptr (ptr_q),
    .win (win)
  );

  // Index and requested length of the round-robin winner.
  always_comb begin
    win_id  = '0;
    win_len = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win[i]) begin
        win_id  = 2'(i);
        win_len = bus.req_len[i*LENW +: LENW];
      end
    end
  end

  // Current payload byte of the frame owner.
  always_comb begin
    pay_byte = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_q[i]) begin
        pay_byte = bus.req_data[i*8 +: 8];
      end
    end
  end

  assign start   = (state_q == ST_IDLE) && (|bus.req_valid);
  assign wr      = (state_q != ST_IDLE) && !bus.wi_full;
  assign pay_wr  = (state_q == ST_PAYLOAD) && wr;
  assign ptr_nxt = (int'(win_id) == NREQ - 1) ? '0 : PW'(int'(win_id) + 1);
  assign len16   = 16'(len_reg);

  // State register.
  always_ff @(posedge clk) begin
    if (res) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: header bytes advance only on an accepted write.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (start) state_d = ST_TAG;
      ST_TAG:     if (wr)    state_d = ST_LEN_H;
      ST_LEN_H:   if (wr)    state_d = ST_LEN_L;
      ST_LEN_L:   if (wr)    state_d = (len_reg == '0) ? ST_IDLE : ST_PAYLOAD;
      ST_PAYLOAD: if (wr && (cnt == LENW'(1))) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Byte presented to the FIFO in each state.
  always_comb begin
    out_byte = '0;
    case (state_q)
      ST_TAG:     out_byte = make_tag(gid_q);
      ST_LEN_H:   out_byte = len16[15:8];
      ST_LEN_L:   out_byte = len16[7:0];
      ST_PAYLOAD: out_byte = pay_byte;
      default:    out_byte = '0;
    endcase
  end

  // Grant, pointer and length bookkeeping; length is frozen at grant time.
  always_ff @(posedge clk) begin
    if (res) begin
      grant_q <= '0;
      gid_q   <= '0;
      ptr_q   <= '0;
      len_reg <= '0;
      cnt     <= '0;
    end else if (start) begin
      grant_q <= win;
      gid_q   <= win_id;
      ptr_q   <= ptr_nxt;
      len_reg <= win_len;
      cnt     <= win_len;
    end else begin
      if (pay_wr) begin
        cnt <= cnt - LENW'(1);
      end
      if ((state_q != ST_IDLE) && (state_d == ST_IDLE)) begin
        grant_q <= '0;
      end
    end
  end

  assign bus.wi_data  = out_byte;
  assign bus.wi_write = wr;
  assign bus.req_ack  = pay_wr ? grant_q : '0;
  assign bus.grant    = grant_q;
  assign bus.state    = state_q;

endmodule

// File: doc/tx_frame_arbiter.md
TX_FRAME_ARBITER -- requirements
Module: tx_frame_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 2, number of response sources sharing the FTDI TX FIFO (legal 2..4).
REQ-002 SHALL have parameter LENW, default 16, payload length width in bytes.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  clock; all logic on rising edge.
REQ-005 res  in  1  synchronous active-high reset.
REQ-006 req_valid  in  NREQ  source i has a frame pending; held high until the frame completes.
REQ-007 req_len  in  NREQ*LENW  payload byte count of source i; slice i is [i*LENW +: LENW].
REQ-008 req_data  in  NREQ*8  current payload byte of source i (first-word-fall-through).
REQ-009 req_ack  out  NREQ  payload byte of source i consumed this cycle.
REQ-010 wi_data  out  8  byte to FTDI TX FIFO.
REQ-011 wi_write  out  1  write enable to FTDI TX FIFO.
REQ-012 wi_full  in  1  FTDI TX FIFO full.
REQ-013 grant  out  NREQ  one-hot owner of the current frame; all zero in IDLE.
REQ-014 state  out  3  debug copy of the current state encoding.

Function
REQ-015 Frame on wi_data SHALL be: tag byte, length MSB, length LSB, then exactly len payload bytes. Tag = {4'hA, 2'b00, id[1:0]}.
REQ-016 States SHALL be IDLE, TAG, LEN_H, LEN_L and PAYLOAD.
REQ-017 IDLE: if any req_valid is set, the block SHALL pick a winner round-robin, starting from the source after the last granted one. It SHALL register grant, latch req_len of the winner into len_reg and cnt, and go to TAG. Otherwise it stays in IDLE.
REQ-018 Round-robin pointer SHALL update only on a grant; after reset, source 0 has highest priority.
REQ-019 wi_write SHALL equal (state is TAG, LEN_H, LEN_L or PAYLOAD) AND !wi_full, combinationally. No byte is written while wi_full=1.
REQ-020 TAG, LEN_H, LEN_L SHALL advance to the next state only on a cycle with wi_write=1.
REQ-021 LEN_L on write: if len_reg==0, go to IDLE (header-only frame, no req_ack). Otherwise go to PAYLOAD.
REQ-022 PAYLOAD: wi_data SHALL be req_data of the granted source. req_ack[g] SHALL equal wi_write; all other req_ack bits are 0.
REQ-023 PAYLOAD on write: cnt decrements by 1. If cnt==1 before the decrement, go to IDLE in the same edge.
REQ-024 Latency: req_valid sampled at edge k in IDLE puts the tag on wi_data/wi_write from edge k+1 when wi_full=0. A back-to-back frame from another source starts its tag 1 cycle after the last payload byte (one IDLE cycle).
REQ-025 Deassertion of req_valid[g] mid-frame SHALL be ignored; the frame runs to completion.
REQ-026 req_len changes after the grant SHALL be ignored.
REQ-027 Simultaneous requests SHALL be served in round-robin order, one full frame each; no starvation.
REQ-028 Length arithmetic SHALL be LENW-bit unsigned. len=2^LENW-1 SHALL be legal without wrap.

Reset
REQ-029 On res=1 at a clock edge, all state SHALL clear, even mid-frame: state=IDLE, grant=0, req_ack=0, wi_write=0, wi_data=0, cnt=0, len_reg=0, rr pointer=0.
REQ-030 A frame truncated by reset SHALL NOT resume. Host-side resync is out of scope.

Structure
REQ-031 State encodings, TAG_PREFIX (4'hA) and the tag-format constants SHALL be in the shared package ftdi_pkg.
REQ-032 Round-robin selection SHALL be a sub-module rr_pick. Inputs: request vector and pointer. Output: one-hot winner. Purely combinational, instantiated once.
REQ-033 The FSM, cnt and len_reg SHALL reside in tx_frame_arbiter. Estimated size is 150-250 lines.

Verification
REQ-034 Single frame: src0 valid, len=3, data 11,22,33, wi_full=0 -> wi_data A0,00,03,11,22,33 on 6 consecutive cycles; req_ack[0] high on the last 3 cycles.
REQ-035 Zero length: src1 valid, len=0 -> A1,00,00; req_ack never asserted; IDLE next.
REQ-036 Contention: src0 and src1 both valid from reset, len=1 each, re-asserted -> frame order src0, src1, src0; one IDLE cycle between frames.
REQ-037 Backpressure: wi_full=1 for 4 cycles during PAYLOAD of a len=4 frame -> no wi_write/req_ack while full; byte sequence intact, no duplicate or skipped byte.
REQ-038 Reset mid-frame: res=1 after 2 payload bytes of len=5 -> next cycle grant=0, wi_write=0, state=IDLE. A new src1 request then yields tag A1 (pointer reset).
REQ-039 Max length: len=FFFF, random wi_full -> exactly 65535 payload writes, then IDLE.
